outport_buffer: RTL and testbench

//  Buffered, parametrised successor to the single-register output port.

---
 rtl/outport_pkg.sv | 27 ++
 rtl/outport_fifo_mem.sv | 27 ++
 rtl/outport_buffer.sv | 109 ++++++++++
 tb/tb_outport_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/outport_pkg.sv
// Shared constants and helpers for the buffered output port.
// Status-word layout is used only when OUTPORT_STATUS_EN is defined.
package outport_pkg;

  localparam int STAT_OVF     = 15;
  localparam int STAT_FULL    = 14;
  localparam int STAT_EMPTY   = 13;
  localparam int STAT_CNT_LSB = 0;
  localparam int STAT_CNT_W   = 8;

  // Packs the flag bits and the occupancy into the 32-bit status word.
  function automatic logic [31:0] status_word(
    input logic                  ovf,
    input logic                  is_full,
    input logic                  is_empty,
    input logic [STAT_CNT_W-1:0] cnt
  );
    logic [31:0] w;
    w = 32'b0;
    w[STAT_OVF]   = ovf;
    w[STAT_FULL]  = is_full;
    w[STAT_EMPTY] = is_empty;
    w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/outport_fifo_mem.sv
// Storage array for the output FIFO: one synchronous write port and one
// combinational read port, no reset on the contents.
module outport_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read gives first-word fall-through at the FIFO head.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/outport_buffer.sv
// Buffered output port: FIFO of bus writes drained over valid/ready, plus the
// legacy last-written register. Optional status word under OUTPORT_STATUS_EN.
module outport_buffer
  import outport_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  outport_enable,
  input  logic [DATA_WIDTH-1:0] bus_Data,
  output logic [DATA_WIDTH-1:0] outport_Data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  input  logic                  overflow_clr
`ifdef OUTPORT_STATUS_EN
  ,
  input  logic                  status_select,
  output logic [31:0]           status_Data
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          push;
  logic          drop;

  // Handshake: a word transfers on a clock edge where out_valid and out_ready
  // are both high; out_valid never waits on out_ready, and out_ready may be
  // raised or dropped freely, including while out_valid is low.
  assign out_valid = (count != '0);
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));

  assign pop  = out_valid & out_ready;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push = outport_enable & (~full | pop);
  assign drop = outport_enable & full & ~pop;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped write sets the sticky flag even if software clears it that cycle.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  // Legacy view tracks every write attempt, accepted or not.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      outport_Data <= '0;
    end else if (outport_enable) begin
      outport_Data <= bus_Data;
    end
  end

  outport_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr),
    .wr_data (bus_Data),
    .rd_addr (rd_ptr),
    .rd_data (out_data)
  );

`ifdef OUTPORT_STATUS_EN
  // Zero when unselected so the word can be OR-ed onto the bus mux.
  assign status_Data = status_select
                     ? status_word(overflow, full, empty, STAT_CNT_W'(count))
                     : 32'b0;
`endif

endmodule

// File: tb/tb_outport_buffer.sv
// Randomized scoreboard bench for outport_buffer; the status-word checks are
// compiled in only when OUTPORT_STATUS_EN is defined.
module tb_outport_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          clear_n;
  logic          outport_enable;
  logic [DW-1:0] bus_Data;
  logic [DW-1:0] outport_Data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          overflow_clr;
`ifdef OUTPORT_STATUS_EN
  logic          status_select;
  logic [31:0]   status_Data;
`endif

  outport_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .clear_n        (clear_n),
    .outport_enable (outport_enable),
    .bus_Data       (bus_Data),
    .outport_Data   (outport_Data),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr)
`ifdef OUTPORT_STATUS_EN
    ,
    .status_select  (status_select),
    .status_Data    (status_Data)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int            vectors    = 0;
  int            miscompares = 0;

  // Reference model: occupancy, sticky flag and last write as plain values.
  int            mdl_cnt  = 0;
  logic          mdl_ovf  = 1'b0;
  logic [DW-1:0] mdl_last = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    check("out_valid", 32'(out_valid), 32'(mdl_cnt > 0));
    check("count", 32'(count), 32'(mdl_cnt));
    check("full", 32'(full), 32'(mdl_cnt == DEPTH));
    check("empty", 32'(empty), 32'(mdl_cnt == 0));
    check("overflow", 32'(overflow), 32'(mdl_ovf));
    check("outport_Data", outport_Data, mdl_last);
    check("count_bound", 32'(int'(count) <= DEPTH), 32'd1);
    if (mdl_cnt > 0 && exp_q.size() > 0) begin
      check("head", out_data, exp_q[0]);
    end
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of stimulus, advances the model across the edge, then
  // checks the DUT state just after the edge.
  task automatic step(input logic en, input logic [DW-1:0] d, input logic rdy, input logic clr);
    logic pop_m;
    logic push_m;
    outport_enable = en;
    bus_Data       = d;
    out_ready      = rdy;
    overflow_clr   = clr;
    pop_m  = rdy && (mdl_cnt > 0);
    push_m = en && ((mdl_cnt < DEPTH) || pop_m);
    if (push_m) exp_q.push_back(d);
    @(posedge clk);
    #1;
    mdl_cnt = mdl_cnt + int'(push_m) - int'(pop_m);
    if (en) mdl_last = d;
    if (en && !push_m) mdl_ovf = 1'b1;
    else if (clr) mdl_ovf = 1'b0;
    check_state();
  endtask

  task automatic idle_inputs();
    outport_enable = 1'b0;
    bus_Data       = '0;
    out_ready      = 1'b0;
    overflow_clr   = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_outport_Data", outport_Data, 32'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_cnt  = 0;
    mdl_ovf  = 1'b0;
    mdl_last = '0;
  endtask

  // ---------------- monitor ----------------
  // Samples on the falling edge: a transfer will happen at the next rising edge.
  always @(negedge clk) begin
    if (clear_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got %h expected none at %0t", out_data, $time);
      end else begin
        check("pop_data", out_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clear_n = 1'b0;
    idle_inputs();
`ifdef OUTPORT_STATUS_EN
    status_select = 1'b0;
`endif
    #2;
    check_reset_values();
    #1 clear_n = 1'b1;

    // Single push with the consumer stalled; word must fall through at once.
    step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    check("t2_out_valid", 32'(out_valid), 32'd1);
    check("t2_out_data", out_data, 32'hA5A5_0001);
    check("t2_count", 32'(count), 32'd1);
    check("t2_outport_Data", outport_Data, 32'hA5A5_0001);
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill, overfill once, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
    check("t3_full", 32'(full), 32'd1);
    step(1'b1, 32'h18, 1'b0, 1'b0);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_count", 32'(count), 32'd8);
    check("t3_outport_Data", outport_Data, 32'h18);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("t3_empty", 32'(empty), 32'd1);

    // Clear the flag, refill, then write and read together while full.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h20 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h28, 1'b1, 1'b0);
    check("t4_count", 32'(count), 32'd8);
    check("t4_overflow", 32'(overflow), 32'd0);
    check("t4_head", out_data, 32'h21);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with wrap-around and occasional flag clears.
    for (int i = 0; i < 120; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset mid-run with data in flight.
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b0);
    idle_inputs();
    #2 clear_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk);
    #2 clear_n = 1'b1;
    @(posedge clk);
    #1;
    check_state();

`ifdef OUTPORT_STATUS_EN
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 32'h40 + 32'(i), 1'b0, 1'b0);
    check("t6_status_unselected", status_Data, 32'h0);
    status_select = 1'b1;
    #1;
    check("t6_status_ovf", status_Data, 32'h0000_C008);
    step(1'b0, '0, 1'b0, 1'b1);
    check("t6_status_clr", status_Data, 32'h0000_4008);
    status_select = 1'b0;
`endif

    // Final drain: every expected word must have come out.
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
